// File: rtl/image_downscale.sv
// Streaming power-of-two downscaler: decimate or box-average raster pixels into a linear write address.
// Averaging is compiled in only when IMAGE_DOWNSCALE_AVG_EN is defined; otherwise decimate only.
module image_downscale #(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int HEIGHT = 64,
  parameter int LOG_FACTOR = 1,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int NW = WIDTH >> LOG_FACTOR,
  localparam int NH = HEIGHT >> LOG_FACTOR,
  localparam int AW = (NW * NH > 1) ? $clog2(NW * NH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 mode_in,
  input  logic [BIT_DEPTH-1:0] data_in,
  input  logic [XW-1:0]        data_x_in,
  input  logic [YW-1:0]        data_y_in,
  input  logic                 data_valid_in,
  output logic [BIT_DEPTH-1:0] data_out,
  output logic [AW-1:0]        data_addr_out,
  output logic                 data_valid_out,
  output logic                 done_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic                  mode_reg;
  logic                  mode_next;
  logic                  mode_eff;
  logic [LOG_FACTOR-1:0] sx;
  logic [LOG_FACTOR-1:0] sy;
  logic                  origin;
  logic                  accept;
  logic                  blk_first;
  logic                  blk_last;
  logic                  bx_last;
  logic                  by_last;
  logic                  emit;
  logic                  emit_done;
  logic [AW-1:0]         addr_calc;
  logic [BIT_DEPTH-1:0]  pix_calc;

  assign sx        = data_x_in[LOG_FACTOR-1:0];
  assign sy        = data_y_in[LOG_FACTOR-1:0];
  assign origin    = data_valid_in && (data_x_in == '0) && (data_y_in == '0);
  assign accept    = rst_in && data_valid_in && (origin || (state_reg == ST_RUN));
  assign blk_first = (sx == '0) && (sy == '0);
  assign blk_last  = (&sx) && (&sy);
  assign bx_last   = (data_x_in >> LOG_FACTOR) == XW'(NW - 1);
  assign by_last   = (data_y_in >> LOG_FACTOR) == YW'(NH - 1);
  assign addr_calc = AW'(data_y_in >> LOG_FACTOR) * AW'(NW) + AW'(data_x_in >> LOG_FACTOR);

  // The (0,0) pixel uses the freshly presented mode so the frame's first pixel is handled correctly.
  assign mode_eff = origin ? mode_next : mode_reg;

`ifdef IMAGE_DOWNSCALE_AVG_EN
  localparam int ACW = BIT_DEPTH + 2 * LOG_FACTOR;
  localparam int BXW = (NW > 1) ? $clog2(NW) : 1;

  logic [ACW-1:0] acc_reg [NW];
  logic [BXW-1:0] bx_idx;
  logic [ACW-1:0] acc_sum;

  assign mode_next = mode_in;
  assign bx_idx    = BXW'(data_x_in >> LOG_FACTOR);
  assign acc_sum   = acc_reg[bx_idx] + ACW'(data_in);

  // No reset: the top-left pixel of every block overwrites its entry.
  always_ff @(posedge clk_in) begin
    if (accept && mode_eff) begin
      acc_reg[bx_idx] <= blk_first ? ACW'(data_in) : acc_sum;
    end
  end

  // Top BIT_DEPTH bits of the block sum are the truncated mean.
  assign pix_calc = mode_eff ? acc_sum[ACW-1 -: BIT_DEPTH] : data_in;
`else
  assign mode_next = 1'b0;
  assign pix_calc  = data_in;
`endif

  assign emit      = accept && (mode_eff ? blk_last : blk_first);
  assign emit_done = emit && bx_last && by_last;

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = emit_done ? ST_IDLE : ST_RUN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= 1'b0;
      data_out       <= '0;
      data_addr_out  <= '0;
      data_valid_out <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_valid_out <= emit;
      done_out       <= emit_done;
      if (origin) begin
        mode_reg <= mode_next;
      end
      if (emit) begin
        data_out      <= pix_calc;
        data_addr_out <= addr_calc;
      end
    end
  end

endmodule

// File: tb/tb_image_downscale.sv
// Randomized bench for image_downscale (8x8 image, LOG_FACTOR 1 and 3 instances) against a block-level model.
module tb_image_downscale;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       valid;
  logic [7:0] din;
  logic [2:0] x;
  logic [2:0] y;
  logic [7:0] dout1;
  logic [7:0] dout3;
  logic [3:0] addr1;
  logic [0:0] addr3;
  logic       v1;
  logic       v3;
  logic       d1;
  logic       d3;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat_bad;
  int got1[$];
  int got3[$];
  int exp1[$];
  int exp3[$];
  int img[64];

  always #5 clk = ~clk;

  image_downscale #(.BIT_DEPTH(8), .WIDTH(8), .HEIGHT(8), .LOG_FACTOR(1)) dut (
    .clk_in(clk), .rst_in(rst_n), .mode_in(mode), .data_in(din), .data_x_in(x), .data_y_in(y),
    .data_valid_in(valid), .data_out(dout1), .data_addr_out(addr1), .data_valid_out(v1), .done_out(d1)
  );

  image_downscale #(.BIT_DEPTH(8), .WIDTH(8), .HEIGHT(8), .LOG_FACTOR(3)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .mode_in(mode), .data_in(din), .data_x_in(x), .data_y_in(y),
    .data_valid_in(valid), .data_out(dout3), .data_addr_out(addr3), .data_valid_out(v3), .done_out(d3)
  );

  // One clock; outputs sampled 1 time unit after the edge, before inputs change.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (v1) begin
      got1.push_back((int'(d1) << 16) | (int'(addr1) << 8) | int'(dout1));
      if (!valid) lat_bad++;
    end
    if (v3) begin
      got3.push_back((int'(d3) << 16) | (int'(addr3) << 8) | int'(dout3));
      if (!valid) lat_bad++;
    end
  endtask

  task automatic drive(input bit m0, input int toggle_at, input int gap_max, input int first, input int last);
    for (int i = first; i < last; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) cycle();
      x = 3'(i % 8);
      y = 3'(i / 8);
      din = 8'(img[i]);
      mode = (i < toggle_at) ? m0 : ~m0;
      valid = 1'b1;
      cycle();
      valid = 1'b0;
    end
    cycle();
  endtask

  task automatic clear();
    got1.delete();
    got3.delete();
    exp1.delete();
    exp3.delete();
    lat_bad = 0;
  endtask

  // Expected outputs in raster block order: {done, addr, value}.
  task automatic model(input bit m);
    bit me;
`ifdef IMAGE_DOWNSCALE_AVG_EN
    me = m;
`else
    me = 1'b0;
    if (m) me = 1'b0;
`endif
    for (int lf = 1; lf <= 3; lf += 2) begin
      int f;
      int nw;
      f = 1 << lf;
      nw = 8 >> lf;
      for (int by = 0; by < nw; by++) begin
        for (int bx = 0; bx < nw; bx++) begin
          int sum;
          int val;
          int w;
          sum = 0;
          for (int sy = 0; sy < f; sy++)
            for (int sx = 0; sx < f; sx++)
              sum += img[(by * f + sy) * 8 + bx * f + sx];
          val = me ? sum / (f * f) : img[by * f * 8 + bx * f];
          w = (((by == nw - 1) && (bx == nw - 1)) ? 1 << 16 : 0) | ((by * nw + bx) << 8) | val;
          if (lf == 1) exp1.push_back(w);
          else exp3.push_back(w);
        end
      end
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) img[i] = i;
  endtask

  task automatic test_reset();
    clear();
    rst_n = 1'b0;
    x = 3'd0;
    y = 3'd0;
    din = 8'hAA;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    cycle();
    total_cnt++;
    if ({v1, d1, dout1, addr1} !== 14'd0) $display("FAIL reset_outputs: got %h expected 0", {v1, d1, dout1, addr1});
    else pass_cnt++;
    total_cnt++;
    if ({v3, d3, dout3, addr3} !== 11'd0) $display("FAIL reset_outputs3: got %h expected 0", {v3, d3, dout3, addr3});
    else pass_cnt++;
    rst_n = 1'b1;
    cycle();
    fill_ramp();
    drive(1'b0, 64, 0, 1, 64);
    total_cnt++;
    if (got1.size() + got3.size() !== 0) $display("FAIL idle_ignore: got %0d outputs expected 0", got1.size() + got3.size());
    else pass_cnt++;
  endtask

  task automatic test_decimate();
    clear();
    fill_ramp();
    drive(1'b0, 64, 0, 0, 64);
    model(1'b0);
    total_cnt++;
    if (got1.size() !== exp1.size()) $display("FAIL dec_count: got %0d expected %0d", got1.size(), exp1.size());
    else pass_cnt++;
    for (int k = 0; k < exp1.size(); k++) begin
      total_cnt++;
      if ((k < got1.size() ? got1[k] : -1) !== exp1[k])
        $display("FAIL dec_out[%0d]: got %h expected %h", k, (k < got1.size() ? got1[k] : -1), exp1[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (got3.size() !== 1 || got3[0] !== exp3[0]) $display("FAIL dec_out3: got %0d items expected %h", got3.size(), exp3[0]);
    else pass_cnt++;
  endtask

  task automatic test_average();
    for (int s = 0; s < 2; s++) begin
      clear();
      for (int i = 0; i < 64; i++) img[i] = (s == 0) ? i : 255;
      drive(1'b1, 64, 0, 0, 64);
      model(1'b1);
      total_cnt++;
      if (got1.size() !== exp1.size()) $display("FAIL avg_count[%0d]: got %0d expected %0d", s, got1.size(), exp1.size());
      else pass_cnt++;
      for (int k = 0; k < exp1.size(); k++) begin
        total_cnt++;
        if ((k < got1.size() ? got1[k] : -1) !== exp1[k])
          $display("FAIL avg_out[%0d.%0d]: got %h expected %h", s, k, (k < got1.size() ? got1[k] : -1), exp1[k]);
        else pass_cnt++;
      end
      total_cnt++;
      if (got3.size() !== 1 || got3[0] !== exp3[0]) $display("FAIL avg_out3[%0d]: got %0d items expected %h", s, got3.size(), exp3[0]);
      else pass_cnt++;
      total_cnt++;
      if (lat_bad !== 0) $display("FAIL avg_latency[%0d]: got %0d late outputs expected 0", s, lat_bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_gaps();
    for (int m = 0; m < 2; m++) begin
      clear();
      for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(255, 0));
      drive(m[0], 64, 5, 0, 64);
      model(m[0]);
      total_cnt++;
      if (got1.size() !== exp1.size()) $display("FAIL gap_count[%0d]: got %0d expected %0d", m, got1.size(), exp1.size());
      else pass_cnt++;
      for (int k = 0; k < exp1.size(); k++) begin
        total_cnt++;
        if ((k < got1.size() ? got1[k] : -1) !== exp1[k])
          $display("FAIL gap_out[%0d.%0d]: got %h expected %h", m, k, (k < got1.size() ? got1[k] : -1), exp1[k]);
        else pass_cnt++;
      end
      total_cnt++;
      if (got3.size() !== 1 || got3[0] !== exp3[0]) $display("FAIL gap_out3[%0d]: got %0d items expected %h", m, got3.size(), exp3[0]);
      else pass_cnt++;
      total_cnt++;
      if (lat_bad !== 0) $display("FAIL gap_latency[%0d]: got %0d late outputs expected 0", m, lat_bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midframe();
    int dones;
    fill_ramp();
    drive(1'b0, 64, 0, 0, 20);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    clear();
    drive(1'b0, 64, 0, 20, 64);
    drive(1'b0, 64, 0, 0, 64);
    model(1'b0);
    dones = 0;
    foreach (got1[k]) if (got1[k][16]) dones++;
    total_cnt++;
    if (dones !== 1) $display("FAIL rst_mid_done: got %0d done pulses expected 1", dones);
    else pass_cnt++;
    total_cnt++;
    if (got1.size() !== exp1.size()) $display("FAIL rst_mid_count: got %0d expected %0d", got1.size(), exp1.size());
    else pass_cnt++;
    for (int k = 0; k < exp1.size(); k++) begin
      total_cnt++;
      if ((k < got1.size() ? got1[k] : -1) !== exp1[k])
        $display("FAIL rst_mid_out[%0d]: got %h expected %h", k, (k < got1.size() ? got1[k] : -1), exp1[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mode_latch();
    clear();
    for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(255, 0));
    drive(1'b1, 30, 0, 0, 64);
    drive(1'b0, 64, 0, 0, 64);
    model(1'b1);
    model(1'b0);
    total_cnt++;
    if (got1.size() !== exp1.size()) $display("FAIL latch_count: got %0d expected %0d", got1.size(), exp1.size());
    else pass_cnt++;
    for (int k = 0; k < exp1.size(); k++) begin
      total_cnt++;
      if ((k < got1.size() ? got1[k] : -1) !== exp1[k])
        $display("FAIL latch_out[%0d]: got %h expected %h", k, (k < got1.size() ? got1[k] : -1), exp1[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (got3.size() !== 2 || got3[0] !== exp3[0] || got3[1] !== exp3[1])
      $display("FAIL latch_out3: got %0d items expected %h %h", got3.size(), exp3[0], exp3[1]);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    valid = 1'b0;
    din = 8'd0;
    x = 3'd0;
    y = 3'd0;
    lat_bad = 0;
    test_reset();
    test_decimate();
    test_average();
    test_gaps();
    test_reset_midframe();
    test_mode_latch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
